// File: rtl/pipe_scoreboard.sv
// Issue-stage hazard controller: per-register pending-write counters gate the ID->EX
// handshake on RAW / WAW-capacity hazards, and a RUN/DRAIN FSM sequences flushes.
module pipe_scoreboard #(
   parameter int NREG  = 32,
   parameter int AW    = $clog2(NREG),
   parameter int CNT_W = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          id_valid_i,
   output logic          id_ready_o,
   input  logic [AW-1:0] rs1_i,
   input  logic [AW-1:0] rs2_i,
   input  logic          rs1_used_i,
   input  logic          rs2_used_i,
   input  logic [AW-1:0] rd_i,
   input  logic          rd_wen_i,
   output logic          ex_valid_o,
   input  logic          ex_ready_i,
   input  logic          wb_valid_i,
   input  logic [AW-1:0] wb_rd_i,
   input  logic          kill_valid_i,
   input  logic [AW-1:0] kill_rd_i,
   input  logic          flush_i,
   output logic          busy_o,
   output logic          draining_o,
   output logic [31:0]   stall_cnt_o,
   output logic          err_o
);

   localparam int PT_W = $clog2(NREG * (2 ** CNT_W)) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q [NREG];
   logic [CNT_W-1:0]  cnt_d [NREG];
   logic [PT_W-1:0]   total_q, total_d;
   logic [31:0]       stall_q, stall_d;
   logic              err_q, err_d;

   logic              hazard;
   logic              ok;
   logic              fire;
   logic              underflow;

   // Counter update: signed sum of increment and up to two releases; a negative
   // result clamps to zero and flags the underflow in the MSB of the return value.
   function automatic logic [CNT_W:0] cnt_update(input logic [CNT_W-1:0] cur,
                                                 input logic             inc,
                                                 input logic [1:0]       dec);
      logic signed [CNT_W+2:0] sum;
      sum = $signed({3'b000, cur})
          + $signed({{(CNT_W+2){1'b0}}, inc})
          - $signed({{(CNT_W+1){1'b0}}, dec});
      if (sum < 0) begin
         return {1'b1, {CNT_W{1'b0}}};
      end
      return {1'b0, sum[CNT_W-1:0]};
   endfunction

   always_comb begin
      hazard = 1'b0;
      if (rs1_used_i && (rs1_i != '0) && (cnt_q[rs1_i] != '0)) begin
         hazard = 1'b1;
      end
      if (rs2_used_i && (rs2_i != '0) && (cnt_q[rs2_i] != '0)) begin
         hazard = 1'b1;
      end
      if (rd_wen_i && (rd_i != '0) && (cnt_q[rd_i] == CNT_MAX)) begin
         hazard = 1'b1;
      end
   end

   assign ok         = (state_q == RUN) && !flush_i && !hazard;
   assign ex_valid_o = id_valid_i && ok;
   assign id_ready_o = ex_ready_i && ok;
   assign fire       = ex_valid_o && ex_ready_i;

   // Index 0 is never tracked, so the loop starts at 1 and cnt[0] stays at its reset value.
   always_comb begin
      logic             inc_r;
      logic [1:0]       dec_r;
      logic [CNT_W:0]   upd_r;
      cnt_d     = cnt_q;
      total_d   = total_q;
      underflow = 1'b0;
      inc_r     = 1'b0;
      dec_r     = 2'b00;
      upd_r     = '0;
      for (int r = 1; r < NREG; r++) begin
         inc_r = fire && rd_wen_i && (rd_i == AW'(r));
         dec_r = {1'b0, wb_valid_i && (wb_rd_i == AW'(r))}
               + {1'b0, kill_valid_i && (kill_rd_i == AW'(r))};
         upd_r = cnt_update(cnt_q[r], inc_r, dec_r);
         cnt_d[r]  = upd_r[CNT_W-1:0];
         underflow = underflow | upd_r[CNT_W];
         total_d   = total_d + PT_W'(upd_r[CNT_W-1:0]) - PT_W'(cnt_q[r]);
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (id_valid_i && !id_ready_o) begin
         stall_d = stall_q + 32'd1;
      end
      err_d = err_q | underflow;
   end

   // A flush that finds nothing outstanding (after this cycle's retirements) needs no drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (flush_i && (total_d != '0)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!flush_i && (total_d == '0)) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         total_q <= '0;
         stall_q <= '0;
         err_q   <= 1'b0;
         state_q <= RUN;
      end else begin
         cnt_q   <= cnt_d;
         total_q <= total_d;
         stall_q <= stall_d;
         err_q   <= err_d;
         state_q <= state_d;
      end
   end

   assign busy_o      = (total_q != '0);
   assign draining_o  = (state_q == DRAIN);
   assign stall_cnt_o = stall_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: stimulus queues the expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_scoreboard;
   localparam int AW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          id_valid_i;
   logic          id_ready_o;
   logic [AW-1:0] rs1_i, rs2_i, rd_i, wb_rd_i, kill_rd_i;
   logic          rs1_used_i, rs2_used_i, rd_wen_i;
   logic          ex_valid_o, ex_ready_i;
   logic          wb_valid_i, kill_valid_i, flush_i;
   logic          busy_o, draining_o, err_o;
   logic [31:0]   stall_cnt_o;

   pipe_scoreboard #(.NREG(32), .AW(AW), .CNT_W(2)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .id_valid_i   (id_valid_i),
      .id_ready_o   (id_ready_o),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .rs1_used_i   (rs1_used_i),
      .rs2_used_i   (rs2_used_i),
      .rd_i         (rd_i),
      .rd_wen_i     (rd_wen_i),
      .ex_valid_o   (ex_valid_o),
      .ex_ready_i   (ex_ready_i),
      .wb_valid_i   (wb_valid_i),
      .wb_rd_i      (wb_rd_i),
      .kill_valid_i (kill_valid_i),
      .kill_rd_i    (kill_rd_i),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .draining_o   (draining_o),
      .stall_cnt_o  (stall_cnt_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Packed as {id_ready, ex_valid, busy, draining, err, stall_cnt[31:0]}.
   typedef struct {
      string       name;
      logic [36:0] exp;
      logic [36:0] mask;
   } chk_t;

   chk_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   always @(negedge clk_i) begin
      chk_t        c;
      logic [36:0] act;
      while (exp_q.size() != 0) begin
         c   = exp_q.pop_front();
         act = {id_ready_o, ex_valid_o, busy_o, draining_o, err_o, stall_cnt_o};
         n_total++;
         if ((act & c.mask) === (c.exp & c.mask)) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got rdy/vld/busy/drain/err/stall=%h required %h (mask %h)",
                     c.name, act, c.exp, c.mask);
         end
      end
   end

   task automatic push(input string nm, input logic r, input logic v, input logic b,
                       input logic d, input logic e, input logic [31:0] s, input bit chk_rv);
      chk_t c;
      c.name = nm;
      c.exp  = {r, v, b, d, e, s};
      c.mask = chk_rv ? {37{1'b1}} : {2'b00, {35{1'b1}}};
      exp_q.push_back(c);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      id_valid_i   = 1'b0;
      ex_ready_i   = 1'b1;
      rs1_i        = '0;
      rs2_i        = '0;
      rs1_used_i   = 1'b0;
      rs2_used_i   = 1'b0;
      rd_i         = '0;
      rd_wen_i     = 1'b0;
      wb_valid_i   = 1'b0;
      wb_rd_i      = '0;
      kill_valid_i = 1'b0;
      kill_rd_i    = '0;
      flush_i      = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] rd, input logic wen);
      idle();
      id_valid_i = 1'b1;
      rd_i       = rd;
      rd_wen_i   = wen;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b0;
      idle();
      tick();

      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         id_valid_i   = 1'($urandom);
         ex_ready_i   = 1'($urandom);
         rs1_i        = AW'($urandom);
         rs2_i        = AW'($urandom);
         rs1_used_i   = 1'($urandom);
         rs2_used_i   = 1'($urandom);
         rd_i         = AW'($urandom);
         rd_wen_i     = 1'($urandom);
         wb_valid_i   = 1'($urandom);
         wb_rd_i      = AW'($urandom);
         kill_valid_i = 1'($urandom);
         kill_rd_i    = AW'($urandom);
         flush_i      = 1'($urandom);
         push("reset_hold", 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      idle();
      rst_i = 1'b1;
      push("post_reset", 1, 0, 0, 0, 0, 0, 1);
      tick();
      ex_ready_i = 1'b0;
      push("ex_ready_low", 0, 0, 0, 0, 0, 0, 1);
      tick();

      // RAW on x5
      issue(5, 1);
      push("raw_issue", 1, 1, 0, 0, 0, 0, 1);
      tick();
      idle();
      id_valid_i = 1'b1; rs1_i = 5; rs1_used_i = 1'b1;
      push("raw_stall0", 0, 0, 1, 0, 0, 0, 1);
      tick();
      wb_valid_i = 1'b1; wb_rd_i = 5;
      push("raw_stall1_wb", 0, 0, 1, 0, 0, 1, 1);
      tick();
      wb_valid_i = 1'b0;
      push("raw_release", 1, 1, 0, 0, 0, 2, 1);
      tick();
      idle();
      push("raw_idle", 1, 0, 0, 0, 0, 2, 1);
      tick();

      // x0 never tracked; unused rs2 ignored
      issue(0, 1);
      push("x0_issue", 1, 1, 0, 0, 0, 2, 1);
      tick();
      idle();
      id_valid_i = 1'b1; rs1_i = 0; rs1_used_i = 1'b1;
      push("x0_read", 1, 1, 0, 0, 0, 2, 1);
      tick();
      issue(7, 1);
      push("r7_issue", 1, 1, 0, 0, 0, 2, 1);
      tick();
      idle();
      id_valid_i = 1'b1; rs2_i = 7; rs2_used_i = 1'b0; rs1_i = 0; rs1_used_i = 1'b1;
      push("rs2_unused", 1, 1, 1, 0, 0, 2, 1);
      tick();
      idle();
      wb_valid_i = 1'b1; wb_rd_i = 7;
      push("r7_wb", 1, 0, 1, 0, 0, 2, 1);
      tick();

      // WAW capacity on x9 (max 3 in flight)
      issue(9, 1);
      push("waw1", 1, 1, 0, 0, 0, 2, 1);
      tick();
      push("waw2", 1, 1, 1, 0, 0, 2, 1);
      tick();
      push("waw3", 1, 1, 1, 0, 0, 2, 1);
      tick();
      push("waw_full", 0, 0, 1, 0, 0, 2, 1);
      tick();
      wb_valid_i = 1'b1; wb_rd_i = 9;
      push("waw_full_wb", 0, 0, 1, 0, 0, 3, 1);
      tick();
      push("waw_inc_dec", 1, 1, 1, 0, 0, 4, 1);
      tick();
      wb_valid_i = 1'b0;
      push("waw_refill", 1, 1, 1, 0, 0, 4, 1);
      tick();
      push("waw_full2", 0, 0, 1, 0, 0, 4, 1);
      tick();
      idle();
      wb_valid_i = 1'b1; wb_rd_i = 9;
      for (int i = 0; i < 3; i++) begin
         push("waw_drain", 1, 0, 1, 0, 0, 5, 1);
         tick();
      end
      idle();
      push("waw_empty", 1, 0, 0, 0, 0, 5, 1);
      tick();

      // Flush with nothing outstanding: one blocked cycle, stays RUN
      id_valid_i = 1'b1; flush_i = 1'b1;
      push("flush_empty", 0, 0, 0, 0, 0, 5, 1);
      tick();
      flush_i = 1'b0;
      push("flush_empty_run", 1, 1, 0, 0, 0, 6, 1);
      tick();

      // Flush with two writes outstanding
      issue(10, 1);
      push("fl_issue_a", 1, 1, 0, 0, 0, 6, 1);
      tick();
      issue(11, 1);
      push("fl_issue_b", 1, 1, 1, 0, 0, 6, 1);
      tick();
      issue(3, 1);
      flush_i = 1'b1;
      push("fl_pulse", 0, 0, 1, 0, 0, 6, 1);
      tick();
      flush_i = 1'b0;
      kill_valid_i = 1'b1; kill_rd_i = 10;
      push("fl_kill", 0, 0, 1, 1, 0, 7, 1);
      tick();
      kill_valid_i = 1'b0;
      wb_valid_i = 1'b1; wb_rd_i = 11;
      push("fl_wb", 0, 0, 1, 1, 0, 8, 1);
      tick();
      wb_valid_i = 1'b0;
      push("fl_resume", 1, 1, 0, 0, 0, 9, 1);
      tick();
      idle();
      wb_valid_i = 1'b1; wb_rd_i = 3;
      push("fl_cleanup", 1, 0, 1, 0, 0, 9, 1);
      tick();
      idle();
      push("fl_idle", 1, 0, 0, 0, 0, 9, 1);
      tick();

      // Release of an empty counter sets the sticky error
      wb_valid_i = 1'b1; wb_rd_i = 12;
      push("err_pre", 1, 0, 0, 0, 0, 9, 1);
      tick();
      idle();
      push("err_set", 1, 0, 0, 0, 1, 9, 1);
      tick();
      push("err_sticky", 1, 0, 0, 0, 1, 9, 1);
      tick();

      // Asynchronous reset in the middle of a drain
      issue(13, 1);
      push("rst_issue", 1, 1, 0, 0, 1, 9, 1);
      tick();
      idle();
      flush_i = 1'b1;
      push("rst_flush", 0, 0, 1, 0, 1, 9, 1);
      tick();
      flush_i = 1'b0;
      push("rst_drain", 0, 0, 1, 1, 1, 9, 1);
      tick();
      rst_i = 1'b0;
      push("rst_async", 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b1;
      push("rst_release", 1, 0, 0, 0, 0, 0, 1);
      tick();
      idle();
      id_valid_i = 1'b1; rs1_i = 13; rs1_used_i = 1'b1;
      push("post_rst_raw", 1, 1, 0, 0, 0, 0, 1);
      tick();
      idle();
      tick();

      @(negedge clk_i);
      #1;
      n_total++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL queue_empty: got %0d entries left required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
